surfturf_cmdq_core: RTL and testbench
=====================================

// Module: surfturf_cmdq_core
// PURPOSE
//  Wishbone-target command queue: NUM_CHAN independent single-clock FIFOs, each
//  filled by register writes and drained by an AXI4-Stream master toward the
//  SURF link encoders. Generalises the single-entry runcmd/trig holding registers
//  to parametrised width/depth/channel count, with occupancy readback, sticky
//  overflow flags, per-channel enable and flush. CDC happens outside this block.
// PARAMETERS
//  NUM_CHAN    4   number of command channels, 1..8
//  DATA_W      16  command width per channel, 1..32
//  DEPTH_LOG2  4   FIFO depth = 2**DEPTH_LOG2 entries, 1..8
//  ADDR_W      10  Wishbone byte-address width
// PORTS
//  wb_clk_i     in   1                  sole clock
//  wb_rst_ni    in   1                  reset, synchronous, active-low
//  wb_cyc_i     in   1                  WB cycle
//  wb_stb_i     in   1                  WB strobe
//  wb_we_i      in   1                  WB write enable
//  wb_adr_i     in   ADDR_W             WB byte address
//  wb_sel_i     in   4                  WB byte selects
//  wb_dat_i     in   32                 WB write data
//  wb_dat_o     out  32                 WB read data
//  wb_ack_o     out  1                  WB ack
//  wb_err_o     out  1                  tied 0
//  wb_rty_o     out  1                  tied 0
//  cmd_tdata    out  NUM_CHAN*DATA_W    channel ch at [ch*DATA_W +: DATA_W]
//  cmd_tvalid   out  NUM_CHAN           per-channel valid
//  cmd_tready   in   NUM_CHAN           per-channel ready
// BEHAVIOUR
//  Reset (wb_rst_ni=0 at edge): FIFOs empty, enables 0, overflow 0, ack 0,
//   cmd_tvalid 0, wb_dat_o 0. Applies mid-transfer; in-flight entries are lost.
//  WB: ack <= cyc&stb&!ack&rst_n; wb_ack_o = ack&cyc. Single-cycle latency.
//   Writes take effect on the ack cycle only (one action per transaction).
//  Address map (wb_adr_i[7:0]; unmapped reads 0, unmapped writes ignored):
//   0x00 CTRL RW: [NUM_CHAN-1:0] enable; [8+ch] flush, write-1 pulse, reads 0;
//        [16+ch] overflow sticky, write-1-to-clear. Bytes gated by wb_sel_i.
//   0x04 STAT RO: [ch] empty, [8+ch] full.
//   0x40+4*ch DATA: write with sel[0] pushes wb_dat_i[DATA_W-1:0] into channel
//        ch; read returns count (DEPTH_LOG2+1 bits) zero-extended.
//  FIFO: first-word-fall-through. cmd_tvalid[ch] = enable[ch] & !empty;
//   cmd_tdata = head entry, held stable while tvalid & !tready.
//   Pop when tvalid&tready. Push visible at output the cycle after the ack.
//  Full: push accepted if count<DEPTH or a pop occurs the same cycle; else
//   dropped, overflow[ch] set, count unchanged.
//  Push+pop same cycle: count unchanged, order preserved.
//  Flush: count<=0 and pointers reset; a push in the same write is impossible
//   (different address); a pop the same cycle is ignored; overflow unaffected.
//  Overflow set and W1C clear in the same cycle: set wins.
//  Disabled channel: still accepts pushes, holds contents, tvalid 0.
//  Count range 0..DEPTH; pointers wrap modulo DEPTH.
// STRUCTURE
//  Package surfturf_cmdq_pkg: register offsets (CTRL/STAT/DATA_BASE),
//   CTRL bit-field positions.
//  Sub-module cmdq_fifo_fwft (DATA_W, DEPTH_LOG2): single-clock FWFT FIFO,
//   distributed-RAM storage, push/pop/flush, count/empty/full outputs,
//   push_drop output for overflow. Instantiated NUM_CHAN times in a generate.
// TESTING
//  1 Reset, CTRL=0x1, write 0x40=0x1234 with tready=1 -> ch0 tvalid 1 cycle after
//    ack, tdata 0x1234, count returns 0.
//  2 Enable 0, push 16 words to ch1 (DEPTH_LOG2=4) -> 0x44 reads 16, STAT[9]=1;
//    17th push -> CTRL[17]=1, count 16; write CTRL 0x20000 -> CTRL[17]=0.
//  3 Full ch1, enable, tready=1 during 17th push -> push accepted, no overflow,
//    words pop in order 0..16.
//  4 Fill ch2 with 5 words, tready=0, write CTRL[10]=1 -> count 0, tvalid 0.
//  5 tready toggled randomly on all channels, 1000 pushes at random addresses
//    -> per-channel scoreboard order exact, no overflow.
//  6 Assert wb_rst_ni low mid-stream for 1 cycle -> all counts 0, tvalid 0, CTRL 0.

Source files
------------

// File: rtl/surfturf_cmdq_pkg.sv
// Register map and CTRL/STAT field positions for the SURF command queue.
package surfturf_cmdq_pkg;

  localparam logic [7:0] CtrlOffset = 8'h00;
  localparam logic [7:0] StatOffset = 8'h04;
  localparam logic [7:0] DataBase   = 8'h40;

  localparam int unsigned CtrlFlushLsb = 8;
  localparam int unsigned CtrlOvfLsb   = 16;
  localparam int unsigned StatFullLsb  = 8;

  function automatic logic [7:0] data_offset(input int unsigned ch);
    return DataBase + 8'(ch << 2);
  endfunction

endpackage

// File: rtl/cmdq_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; head entry is read combinationally from storage.
module cmdq_fifo_fwft #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_W-1:0]     push_data_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [DATA_W-1:0]     head_data_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  push_drop_o
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [DATA_W-1:0]     mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DepthCnt);

  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign do_pop      = pop_i & ~empty_o & ~flush_i;
  assign do_push     = push_i & (~full_o | do_pop) & ~flush_i;
  assign push_drop_o = push_i & full_o & ~do_pop & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      if (do_push && !do_pop) count_d = count_q + CntW'(1);
      if (!do_push && do_pop) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/surfturf_cmdq_core.sv
// Wishbone-fed command queue: per-channel FWFT FIFOs drained by AXI4-Stream masters.
module surfturf_cmdq_core
  import surfturf_cmdq_pkg::*;
#(
  parameter int unsigned NUM_CHAN   = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_ni,
  input  logic                         wb_cyc_i,
  input  logic                         wb_stb_i,
  input  logic                         wb_we_i,
  input  logic [ADDR_W-1:0]            wb_adr_i,
  input  logic [3:0]                   wb_sel_i,
  input  logic [31:0]                  wb_dat_i,
  output logic [31:0]                  wb_dat_o,
  output logic                         wb_ack_o,
  output logic                         wb_err_o,
  output logic                         wb_rty_o,
  output logic [NUM_CHAN*DATA_W-1:0]   cmd_tdata,
  output logic [NUM_CHAN-1:0]          cmd_tvalid,
  input  logic [NUM_CHAN-1:0]          cmd_tready
);

  logic                  ack_q, wb_req, wb_wr, ctrl_wr;
  logic [7:0]            adr;
  logic [31:0]           dat_q, rd_data;
  logic [NUM_CHAN-1:0]   enable_q, enable_d, ovf_q, ovf_d, ovf_clr;
  logic [NUM_CHAN-1:0]   flush, push, pop, drop, empty, full;
  logic [DEPTH_LOG2:0]   count [NUM_CHAN];
  logic [DATA_W-1:0]     head  [NUM_CHAN];
  logic                  unused_inputs;

  assign adr     = wb_adr_i[7:0];
  assign wb_req  = wb_cyc_i & wb_stb_i & ~ack_q;
  // Writes act only in the ack cycle so each transaction has exactly one effect.
  assign wb_wr   = ack_q & wb_cyc_i & wb_stb_i & wb_we_i;
  assign ctrl_wr = wb_wr & (adr == CtrlOffset);

  always_comb begin
    enable_d = enable_q;
    flush    = '0;
    ovf_clr  = '0;
    if (ctrl_wr) begin
      if (wb_sel_i[0]) enable_d = wb_dat_i[NUM_CHAN-1:0];
      if (wb_sel_i[1]) flush    = wb_dat_i[CtrlFlushLsb +: NUM_CHAN];
      if (wb_sel_i[2]) ovf_clr  = wb_dat_i[CtrlOvfLsb +: NUM_CHAN];
    end
    // Set beats clear when both land in the same cycle.
    ovf_d = (ovf_q & ~ovf_clr) | drop;
  end

  always_comb begin
    push = '0;
    for (int unsigned ch = 0; ch < NUM_CHAN; ch++) begin
      push[ch] = wb_wr & wb_sel_i[0] & (adr == data_offset(ch));
    end
  end

  always_comb begin
    rd_data = '0;
    if (adr == CtrlOffset) begin
      rd_data[NUM_CHAN-1:0]            = enable_q;
      rd_data[CtrlOvfLsb +: NUM_CHAN]  = ovf_q;
    end else if (adr == StatOffset) begin
      rd_data[NUM_CHAN-1:0]            = empty;
      rd_data[StatFullLsb +: NUM_CHAN] = full;
    end
    for (int unsigned ch = 0; ch < NUM_CHAN; ch++) begin
      if (adr == data_offset(ch)) rd_data[DEPTH_LOG2:0] = count[ch];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      enable_q <= '0;
      ovf_q    <= '0;
    end else begin
      ack_q    <= wb_req;
      dat_q    <= (wb_req && !wb_we_i) ? rd_data : '0;
      enable_q <= enable_d;
      ovf_q    <= ovf_d;
    end
  end

  assign wb_ack_o = ack_q & wb_cyc_i;
  assign wb_dat_o = dat_q;
  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;

  assign cmd_tvalid = enable_q & ~empty;
  assign pop        = cmd_tvalid & cmd_tready;

  for (genvar ch = 0; ch < NUM_CHAN; ch++) begin : g_chan
    cmdq_fifo_fwft #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
      .clk_i       (wb_clk_i),
      .rst_ni      (wb_rst_ni),
      .push_i      (push[ch]),
      .push_data_i (wb_dat_i[DATA_W-1:0]),
      .pop_i       (pop[ch]),
      .flush_i     (flush[ch]),
      .head_data_o (head[ch]),
      .count_o     (count[ch]),
      .empty_o     (empty[ch]),
      .full_o      (full[ch]),
      .push_drop_o (drop[ch])
    );
    assign cmd_tdata[ch*DATA_W +: DATA_W] = head[ch];
  end

  assign unused_inputs = ^{wb_adr_i, wb_sel_i, wb_dat_i};

endmodule

// File: tb/tb_surfturf_cmdq_core.sv
// Scoreboard bench: per-channel expected-word queues filled by bus writes, drained by a monitor.
module tb_surfturf_cmdq_core;

  localparam int NUM_CHAN   = 4;
  localparam int DATA_W     = 16;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        cyc, stb, we;
  logic [9:0]                  adr;
  logic [3:0]                  sel;
  logic [31:0]                 dat_i, dat_o;
  logic                        ack, err, rty;
  logic [NUM_CHAN*DATA_W-1:0]  tdata;
  logic [NUM_CHAN-1:0]         tvalid, tready;

  int n_checks = 0;
  int n_errors = 0;
  logic                        rand_rdy = 1'b0;
  logic [DATA_W-1:0]           exp_q [NUM_CHAN][$];
  int                          popped [NUM_CHAN];
  logic [NUM_CHAN-1:0]         en_model, ovf_model;

  always #5 clk = ~clk;

  surfturf_cmdq_core #(
    .NUM_CHAN   (NUM_CHAN),
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .ADDR_W     (10)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_we_i    (we),
    .wb_adr_i   (adr),
    .wb_sel_i   (sel),
    .wb_dat_i   (dat_i),
    .wb_dat_o   (dat_o),
    .wb_ack_o   (ack),
    .wb_err_o   (err),
    .wb_rty_o   (rty),
    .cmd_tdata  (tdata),
    .cmd_tvalid (tvalid),
    .cmd_tready (tready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic int total_pending();
    int t = 0;
    for (int ch = 0; ch < NUM_CHAN; ch++) t += exp_q[ch].size();
    return t;
  endfunction

  function automatic logic [31:0] ctrl_model();
    logic [31:0] v = '0;
    v[NUM_CHAN-1:0]   = en_model;
    v[16 +: NUM_CHAN] = ovf_model;
    return v;
  endfunction

  function automatic logic [31:0] stat_model();
    logic [31:0] v = '0;
    for (int ch = 0; ch < NUM_CHAN; ch++) begin
      v[ch]     = (exp_q[ch].size() == 0);
      v[8 + ch] = (exp_q[ch].size() == DEPTH);
    end
    return v;
  endfunction

  // Reference model of the register-visible effect of one acked write.
  task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a == 8'h00) begin
      if (s[0]) en_model = d[NUM_CHAN-1:0];
      if (s[1]) for (int ch = 0; ch < NUM_CHAN; ch++) if (d[8 + ch]) exp_q[ch].delete();
      if (s[2]) ovf_model = ovf_model & ~d[16 +: NUM_CHAN];
    end else begin
      for (int ch = 0; ch < NUM_CHAN; ch++) begin
        if (s[0] && a == 8'(64 + 4 * ch)) begin
          if (exp_q[ch].size() < DEPTH ||
              (en_model[ch] && tready[ch] && exp_q[ch].size() > 0))
            exp_q[ch].push_back(d[DATA_W-1:0]);
          else
            ovf_model[ch] = 1'b1;
        end
      end
    end
  endtask

  task automatic wb_xfer(input logic write, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [NUM_CHAN-1:0] rdy_at_ack,
                         output logic [31:0] rdata);
    int n = 0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = write; adr = {2'b00, a}; sel = s; dat_i = d;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 8);
    chk("wb_ack", 32'(ack), 32'd1);
    tready = tready | rdy_at_ack;
    rdata  = dat_o;
    if (write) model_write(a, d, s);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] unused_rd;
    wb_xfer(1'b1, a, d, s, '0, unused_rd);
  endtask

  task automatic wb_rd_chk(input string name, input logic [7:0] a, input logic [31:0] req);
    logic [31:0] rd;
    wb_xfer(1'b0, a, 32'd0, 4'hF, '0, rd);
    chk(name, rd, req);
  endtask

  task automatic drain();
    int n = 0;
    tready = '1;
    while (total_pending() > 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_pending", 32'(total_pending()), 32'd0);
  endtask

  // Monitor: every handshake must deliver the oldest expected word of that channel.
  initial begin
    logic [DATA_W-1:0] w;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int ch = 0; ch < NUM_CHAN; ch++) begin
          if (tvalid[ch] && tready[ch]) begin
            if (exp_q[ch].size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL pop_ch%0d: got 0x%0h required no transfer", ch,
                       tdata[ch*DATA_W +: DATA_W]);
            end else begin
              w = exp_q[ch].pop_front();
              popped[ch]++;
              chk($sformatf("tdata_ch%0d", ch), 32'(tdata[ch*DATA_W +: DATA_W]), 32'(w));
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) tready = 4'($urandom);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; sel = '0; dat_i = '0; tready = '0;
    en_model = '0; ovf_model = '0;
    for (int ch = 0; ch < NUM_CHAN; ch++) popped[ch] = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    wb_rd_chk("rst_ctrl", 8'h00, 32'd0);
    wb_rd_chk("rst_stat", 8'h04, stat_model());

    // 1: single word through channel 0
    tready = '1;
    wb_wr(8'h00, 32'h1, 4'hF);
    wb_wr(8'h40, 32'h1234, 4'h1);
    @(negedge clk);
    chk("t1_tvalid0", 32'(tvalid[0]), 32'd1);
    chk("t1_tdata0", 32'(tdata[15:0]), 32'h1234);
    wb_rd_chk("t1_count0", 8'h40, 32'd0);

    // 2: fill disabled channel 1, then overflow and clear
    tready = '0;
    wb_wr(8'h00, 32'h0, 4'hF);
    for (int i = 0; i < DEPTH; i++) wb_wr(8'h44, 32'h100 + 32'(i), 4'h1);
    wb_rd_chk("t2_count16", 8'h44, 32'(exp_q[1].size()));
    wb_xfer(1'b0, 8'h04, 32'd0, 4'hF, '0, rd);
    chk("t2_stat_full1", 32'(rd[9]), 32'd1);
    chk("t2_stat", rd, stat_model());
    wb_wr(8'h44, 32'hDEAD, 4'h1);
    wb_xfer(1'b0, 8'h00, 32'd0, 4'hF, '0, rd);
    chk("t2_ovf_set", 32'(rd[17]), 32'd1);
    chk("t2_ctrl", rd, ctrl_model());
    wb_rd_chk("t2_count_after_drop", 8'h44, 32'(DEPTH));
    wb_wr(8'h00, 32'h20000, 4'hF);
    wb_rd_chk("t2_ovf_clr", 8'h00, ctrl_model());

    // 3: push into full channel while it pops in the same cycle
    wb_wr(8'h00, 32'h2, 4'hF);
    popped[1] = 0;
    wb_xfer(1'b1, 8'h44, 32'h110, 4'h1, 4'b0010, rd);
    wb_xfer(1'b0, 8'h00, 32'd0, 4'hF, '0, rd);
    chk("t3_no_ovf", 32'(rd[17]), 32'd0);
    drain();
    chk("t3_popped", 32'(popped[1]), 32'd17);
    wb_rd_chk("t3_count_empty", 8'h44, 32'd0);

    // 4: flush a stalled channel
    tready = '0;
    wb_wr(8'h00, 32'h4, 4'hF);
    for (int i = 0; i < 5; i++) wb_wr(8'h48, 32'h200 + 32'(i), 4'h1);
    wb_rd_chk("t4_count5", 8'h48, 32'd5);
    wb_wr(8'h00, 32'h404, 4'hF);
    @(negedge clk);
    chk("t4_tvalid2", 32'(tvalid[2]), 32'd0);
    wb_rd_chk("t4_count0", 8'h48, 32'd0);

    // 5: random traffic with random backpressure
    wb_wr(8'h00, 32'hF, 4'hF);
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      int ch = $urandom_range(0, NUM_CHAN - 1);
      int guard = 0;
      while (exp_q[ch].size() >= DEPTH - 2 && guard < 500) begin
        @(posedge clk);
        ch = $urandom_range(0, NUM_CHAN - 1);
        guard++;
      end
      wb_wr(8'(64 + 4 * ch), $urandom, 4'h1);
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    drain();
    wb_rd_chk("t5_ctrl_no_ovf", 8'h00, ctrl_model());
    for (int ch = 0; ch < NUM_CHAN; ch++)
      wb_rd_chk($sformatf("t5_count_ch%0d", ch), 8'(64 + 4 * ch), 32'd0);

    // 6: reset in the middle of a backlog
    tready = '0;
    for (int i = 0; i < 20; i++) wb_wr(8'(64 + 4 * (i % NUM_CHAN)), $urandom, 4'h1);
    chk("t6_pre_valid", 32'(tvalid), 32'hF);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int ch = 0; ch < NUM_CHAN; ch++) exp_q[ch].delete();
    en_model = '0;
    ovf_model = '0;
    @(negedge clk);
    chk("t6_tvalid", 32'(tvalid), 32'd0);
    for (int ch = 0; ch < NUM_CHAN; ch++)
      wb_rd_chk($sformatf("t6_count_ch%0d", ch), 8'(64 + 4 * ch), 32'd0);
    wb_rd_chk("t6_ctrl", 8'h00, 32'd0);
    wb_rd_chk("t6_stat", 8'h04, stat_model());

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
